// File: rtl/vector_checker_pkg.sv
// Shared types and field-layout helpers for the vector checker.
// A table entry is packed as {in, expected, mask} with the mask in the LSBs.
package vector_checker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int MASK_LSB = 0;

  function automatic int vec_w(input int in_w, input int out_w);
    return in_w + 2 * out_w;
  endfunction

  function automatic int exp_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic int in_lsb(input int out_w);
    return 2 * out_w;
  endfunction

endpackage

// File: rtl/vector_checker_if.sv
// Host/table port, DUT stimulus/response and run status of the vector checker.
// The master side is the harness (host and DUT); the slave side is the checker.
interface vector_checker_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DEPTH = 16,
  parameter int ERR_W = 16
);
  import vector_checker_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = vec_w(IN_W, OUT_W);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [VW-1:0]    wr_data;
  logic             start;
  logic [CW-1:0]    vec_count;
  logic             stop_on_err;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] errors;
  logic             first_err_vld;
  logic [AW-1:0]    first_err_idx;
  logic [OUT_W-1:0] first_err_got;

  modport master (
    output wr_en, wr_addr, wr_data, start, vec_count, stop_on_err, dut_out,
    input  dut_in, busy, done, pass, errors, first_err_vld, first_err_idx, first_err_got
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, vec_count, stop_on_err, dut_out,
    output dut_in, busy, done, pass, errors, first_err_vld, first_err_idx, first_err_got
  );

endinterface

// File: rtl/vector_checker_ram.sv
// Vector table: one write port and one registered read port, no reset.
// A read of the address being written in the same cycle returns the old entry.
module vector_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  // table write and synchronous read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vector_checker.sv
// Test-vector sequencer/checker: applies table vectors to a combinational DUT,
// compares the masked response, counts mismatches and records the first one.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  vector_checker_if.slave   bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int VW      = vec_w(IN_W, OUT_W);
  localparam int SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IN_LSB  = in_lsb(OUT_W);
  localparam int EXP_LSB = exp_lsb(OUT_W);

  state_t           state_r, state_s;
  logic [AW-1:0]    idx_r, idx_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             stop_r, stop_s;
  logic [SW-1:0]    settle_r, settle_s;
  logic [OUT_W-1:0] exp_r, exp_s;
  logic [OUT_W-1:0] mask_r, mask_s;
  logic [IN_W-1:0]  dut_in_r, dut_in_s;
  logic [ERR_W-1:0] errors_r, errors_s;
  logic             fe_vld_r, fe_vld_s;
  logic [AW-1:0]    fe_idx_r, fe_idx_s;
  logic [OUT_W-1:0] fe_got_r, fe_got_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             ram_we_s;
  logic [VW-1:0]    rd_data_s;
  logic [CW-1:0]    cnt_clamp_s;
  logic             mismatch_s;
  logic             last_s;

  // The read address follows the next index so the entry is ready during FETCH.
  vector_ram #(.DEPTH(DEPTH), .W(VW)) u_ram (
    .clk     (clk),
    .we      (ram_we_s),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_s),
    .rd_data (rd_data_s)
  );

  // next-state, datapath and status computation
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    stop_s      = stop_r;
    settle_s    = settle_r;
    exp_s       = exp_r;
    mask_s      = mask_r;
    dut_in_s    = dut_in_r;
    errors_s    = errors_r;
    fe_vld_s    = fe_vld_r;
    fe_idx_s    = fe_idx_r;
    fe_got_s    = fe_got_r;
    ram_we_s    = 1'b0;
    cnt_clamp_s = (bus.vec_count > CW'(DEPTH)) ? CW'(DEPTH) : bus.vec_count;
    mismatch_s  = |((bus.dut_out ^ exp_r) & mask_r);
    last_s      = ({1'b0, idx_r} == (cnt_r - CW'(1)));

    case (state_r)
      IDLE, DONE: begin
        ram_we_s = bus.wr_en;
        if (bus.start) begin
          cnt_s    = cnt_clamp_s;
          stop_s   = bus.stop_on_err;
          idx_s    = {AW{1'b0}};
          errors_s = {ERR_W{1'b0}};
          fe_vld_s = 1'b0;
          fe_idx_s = {AW{1'b0}};
          fe_got_s = {OUT_W{1'b0}};
          state_s  = (cnt_clamp_s == {CW{1'b0}}) ? DONE : FETCH;
        end else begin
          state_s = state_r;
        end
      end
      FETCH: begin
        dut_in_s = rd_data_s[IN_LSB +: IN_W];
        exp_s    = rd_data_s[EXP_LSB +: OUT_W];
        mask_s   = rd_data_s[MASK_LSB +: OUT_W];
        settle_s = {SW{1'b0}};
        state_s  = HOLD;
      end
      HOLD: begin
        if (settle_r == SW'(SETTLE - 1)) begin
          state_s = CHECK;
        end else begin
          settle_s = settle_r + SW'(1);
        end
      end
      CHECK: begin
        if (mismatch_s) begin
          errors_s = (errors_r == {ERR_W{1'b1}}) ? errors_r : errors_r + ERR_W'(1);
          if (!fe_vld_r) begin
            fe_vld_s = 1'b1;
            fe_idx_s = idx_r;
            fe_got_s = bus.dut_out;
          end else begin
            fe_vld_s = fe_vld_r;
          end
        end else begin
          errors_s = errors_r;
        end
        if (last_s || (mismatch_s && stop_r)) begin
          state_s = DONE;
        end else begin
          idx_s   = idx_r + AW'(1);
          state_s = FETCH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == FETCH) || (state_s == HOLD) || (state_s == CHECK);
    done_s = (state_s == DONE);
    pass_s = done_s && (errors_s == {ERR_W{1'b0}});
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      idx_r    <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      stop_r   <= 1'b0;
      settle_r <= {SW{1'b0}};
      exp_r    <= {OUT_W{1'b0}};
      mask_r   <= {OUT_W{1'b0}};
      dut_in_r <= {IN_W{1'b0}};
      errors_r <= {ERR_W{1'b0}};
      fe_vld_r <= 1'b0;
      fe_idx_r <= {AW{1'b0}};
      fe_got_r <= {OUT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      stop_r   <= stop_s;
      settle_r <= settle_s;
      exp_r    <= exp_s;
      mask_r   <= mask_s;
      dut_in_r <= dut_in_s;
      errors_r <= errors_s;
      fe_vld_r <= fe_vld_s;
      fe_idx_r <= fe_idx_s;
      fe_got_r <= fe_got_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      pass_r   <= pass_s;
    end
  end

  assign bus.dut_in        = dut_in_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.pass          = pass_r;
  assign bus.errors        = errors_r;
  assign bus.first_err_vld = fe_vld_r;
  assign bus.first_err_idx = fe_idx_r;
  assign bus.first_err_got = fe_got_r;

endmodule

// File: tb/tb_vector_checker.sv
// Self-checking bench for vector_checker: directed scenarios plus randomized
// tables checked against a per-vector reference model of a checker run.
module tb_vector_checker;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vector_checker_if #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ERR_W(16)) bus0 ();
  vector_checker_if #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ERR_W(2))  bus1 ();

  vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .SETTLE(1), .ERR_W(16)) u0 (
    .clk(clk), .reset(reset), .bus(bus0));
  vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .SETTLE(1), .ERR_W(2)) u1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  logic [2:0] tin   [16];
  logic       texp  [16];
  logic       tmask [16];

  // Combinational DUT under test: y = (~b&~c)|(a&~b), in = {a,b,c}
  function automatic logic golden(input logic [2:0] v);
    return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
  endfunction

  assign bus0.dut_out = golden(bus0.dut_in);
  assign bus1.dut_out = golden(bus1.dut_in);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic golden_table();
    for (int i = 0; i < 16; i++) begin
      tin[i]   = 3'(i % 8);
      texp[i]  = golden(3'(i % 8));
      tmask[i] = 1'b1;
    end
  endtask

  task automatic load0();
    for (int i = 0; i < 16; i++) begin
      bus0.wr_en   = 1'b1;
      bus0.wr_addr = 4'(i);
      bus0.wr_data = {tin[i], texp[i], tmask[i]};
      tick();
    end
    bus0.wr_en = 1'b0;
  endtask

  task automatic run0(input int cnt, input bit stop, output int cyc, output bit busy_bad);
    busy_bad         = 1'b0;
    bus0.vec_count   = 5'(cnt);
    bus0.stop_on_err = stop;
    bus0.start       = 1'b1;
    tick();
    bus0.start = 1'b0;
    cyc        = 0;
    while (!bus0.done && cyc < 400) begin
      if (!bus0.busy) busy_bad = 1'b1;
      tick();
      cyc++;
    end
    if (!bus0.done) cyc = -1;
  endtask

  // Reference: walk the table vector by vector applying the checking rules.
  task automatic model(input int cnt, input bit stop, input int err_w,
                       output int errs, output bit vld, output int fidx,
                       output int fgot, output int nvec);
    int  c;
    int  maxe;
    int  got;
    c    = (cnt > 16) ? 16 : cnt;
    maxe = (1 << err_w) - 1;
    errs = 0; vld = 1'b0; fidx = 0; fgot = 0; nvec = 0;
    for (int i = 0; i < c; i++) begin
      nvec = i + 1;
      got  = int'(golden(tin[i]));
      if (((got ^ int'(texp[i])) & int'(tmask[i])) != 0) begin
        if (errs < maxe) errs++;
        if (!vld) begin vld = 1'b1; fidx = i; fgot = got; end
        if (stop) break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({bus0.dut_in, bus0.busy, bus0.done, bus0.pass, bus0.errors, bus0.first_err_vld,
         bus0.first_err_idx, bus0.first_err_got} !== 28'd0) begin
      failures++; $display("FAIL reset_outputs got=%0d busy=%0d done=%0d exp=all zero",
                           bus0.errors, bus0.busy, bus0.done);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_exhaustive();
    int cyc; bit bb;
    golden_table(); load0();
    run0(8, 1'b0, cyc, bb);
    checks++; if (cyc !== 24) begin failures++; $display("FAIL exh_cycles got=%0d exp=24", cyc); end
    checks++; if (bus0.pass !== 1'b1) begin failures++; $display("FAIL exh_pass got=%0d exp=1", bus0.pass); end
    checks++; if (bus0.errors !== 16'd0) begin failures++; $display("FAIL exh_errors got=%0d exp=0", bus0.errors); end
    checks++; if (bus0.first_err_vld !== 1'b0) begin failures++; $display("FAIL exh_fevld got=%0d exp=0", bus0.first_err_vld); end
    checks++; if (bb !== 1'b0) begin failures++; $display("FAIL exh_busy got=%0d exp=0 drop", bb); end
    checks++; if (bus0.dut_in !== 3'd7) begin failures++; $display("FAIL exh_dut_in got=%0d exp=7", bus0.dut_in); end
  endtask

  task automatic test_one_error();
    int cyc; bit bb;
    golden_table(); texp[5] = 1'b0; load0();
    run0(8, 1'b0, cyc, bb);
    checks++; if (bus0.errors !== 16'd1) begin failures++; $display("FAIL one_errors got=%0d exp=1", bus0.errors); end
    checks++; if (bus0.first_err_idx !== 4'd5) begin failures++; $display("FAIL one_feidx got=%0d exp=5", bus0.first_err_idx); end
    checks++; if (bus0.first_err_got !== 1'b1) begin failures++; $display("FAIL one_fegot got=%0d exp=1", bus0.first_err_got); end
    checks++; if (bus0.pass !== 1'b0) begin failures++; $display("FAIL one_pass got=%0d exp=0", bus0.pass); end
    checks++; if (cyc !== 24) begin failures++; $display("FAIL one_cycles got=%0d exp=24", cyc); end
  endtask

  task automatic test_stop_on_err();
    int cyc; bit bb;
    golden_table(); texp[2] = ~texp[2]; texp[6] = ~texp[6]; load0();
    run0(8, 1'b1, cyc, bb);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL stop_cycles got=%0d exp=9", cyc); end
    checks++; if (bus0.errors !== 16'd1) begin failures++; $display("FAIL stop_errors got=%0d exp=1", bus0.errors); end
    checks++; if (bus0.first_err_idx !== 4'd2) begin failures++; $display("FAIL stop_feidx got=%0d exp=2", bus0.first_err_idx); end
  endtask

  task automatic test_mask();
    int cyc; bit bb;
    golden_table(); texp[5] = ~texp[5]; tmask[5] = 1'b0; load0();
    run0(8, 1'b0, cyc, bb);
    checks++; if (bus0.errors !== 16'd0) begin failures++; $display("FAIL mask_errors got=%0d exp=0", bus0.errors); end
    checks++; if (bus0.pass !== 1'b1) begin failures++; $display("FAIL mask_pass got=%0d exp=1", bus0.pass); end
  endtask

  task automatic test_zero_count();
    int cyc; bit bb;
    reset = 1'b0; tick(); reset = 1'b1;
    run0(0, 1'b0, cyc, bb);
    checks++; if (cyc !== 0) begin failures++; $display("FAIL zero_cycles got=%0d exp=0", cyc); end
    checks++; if (bus0.pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%0d exp=1", bus0.pass); end
    tick(); tick();
    checks++; if ({bus0.busy, bus0.done} !== 2'b01) begin failures++; $display("FAIL zero_busy_done got=%0d exp=1", {bus0.busy, bus0.done}); end
  endtask

  task automatic test_reset_midrun();
    int cyc; bit bb;
    golden_table(); load0();
    bus0.vec_count = 5'd8; bus0.stop_on_err = 1'b0; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (10) tick();
    checks++; if ({bus0.busy, bus0.dut_in} !== 4'b1011) begin failures++; $display("FAIL mid_hold3 got=%0d exp=11", {bus0.busy, bus0.dut_in}); end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus0.dut_in, bus0.busy, bus0.done, bus0.pass, bus0.errors, bus0.first_err_vld,
         bus0.first_err_idx, bus0.first_err_got} !== 28'd0) begin
      failures++; $display("FAIL mid_reset_outputs busy=%0d done=%0d dut_in=%0d exp=all zero",
                           bus0.busy, bus0.done, bus0.dut_in);
    end
    reset = 1'b1;
    run0(8, 1'b0, cyc, bb);
    checks++; if ({bus0.pass, bus0.errors} !== 17'h10000) begin failures++; $display("FAIL mid_rerun_pass got=%0d errs=%0d exp=1", bus0.pass, bus0.errors); end
    checks++; if (cyc !== 24) begin failures++; $display("FAIL mid_rerun_cycles got=%0d exp=24", cyc); end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit bb;
    bus0.vec_count = 5'd8; bus0.stop_on_err = 1'b0; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (4) tick();
    bus0.wr_en = 1'b1; bus0.wr_addr = 4'd3; bus0.wr_data = {3'd3, ~golden(3'd3), 1'b1};
    bus0.start = 1'b1; bus0.vec_count = 5'd1; bus0.stop_on_err = 1'b1;
    tick();
    bus0.wr_en = 1'b0; bus0.start = 1'b0;
    cyc = 5;
    while (!bus0.done && cyc < 400) begin tick(); cyc++; end
    checks++; if (cyc !== 24) begin failures++; $display("FAIL busy_run_cycles got=%0d exp=24", cyc); end
    checks++; if (bus0.errors !== 16'd0) begin failures++; $display("FAIL busy_run_errors got=%0d exp=0", bus0.errors); end
    run0(8, 1'b0, cyc, bb);
    checks++; if (bus0.pass !== 1'b1) begin failures++; $display("FAIL busy_table_kept got=%0d exp=1", bus0.pass); end
  endtask

  task automatic test_random();
    int cyc, cnt, errs, fidx, fgot, nvec; bit bb, stop, vld;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) begin
        tin[i]   = 3'($urandom_range(0, 7));
        texp[i]  = 1'($urandom_range(0, 1));
        tmask[i] = 1'($urandom_range(0, 3) != 0);
      end
      cnt  = int'($urandom_range(0, 31));
      stop = 1'($urandom_range(0, 1));
      load0();
      model(cnt, stop, 16, errs, vld, fidx, fgot, nvec);
      run0(cnt, stop, cyc, bb);
      checks++; if (cyc !== nvec * 3) begin failures++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", it, cyc, nvec * 3); end
      checks++; if (bus0.errors !== 16'(errs)) begin failures++; $display("FAIL rnd%0d_errors got=%0d exp=%0d", it, bus0.errors, errs); end
      checks++; if (bus0.pass !== (errs == 0)) begin failures++; $display("FAIL rnd%0d_pass got=%0d exp=%0d", it, bus0.pass, errs == 0); end
      checks++; if (bus0.first_err_vld !== vld) begin failures++; $display("FAIL rnd%0d_fevld got=%0d exp=%0d", it, bus0.first_err_vld, vld); end
      checks++; if (bb !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy got=%0d exp=0 drop", it, bb); end
      if (vld) begin
        checks++; if ({bus0.first_err_idx, bus0.first_err_got} !== {4'(fidx), 1'(fgot)}) begin
          failures++; $display("FAIL rnd%0d_fe got=%0d/%0d exp=%0d/%0d", it, bus0.first_err_idx, bus0.first_err_got, fidx, fgot);
        end
      end
      if (nvec > 0) begin
        checks++; if (bus0.dut_in !== tin[nvec - 1]) begin failures++; $display("FAIL rnd%0d_dut_in got=%0d exp=%0d", it, bus0.dut_in, tin[nvec - 1]); end
      end
    end
  endtask

  task automatic test_saturate();
    int cyc;
    for (int i = 0; i < 16; i++) begin
      bus1.wr_en   = 1'b1;
      bus1.wr_addr = 4'(i);
      bus1.wr_data = {3'(i % 8), ~golden(3'(i % 8)), 1'b1};
      tick();
    end
    bus1.wr_en = 1'b0;
    bus1.vec_count = 5'd8; bus1.stop_on_err = 1'b0; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    cyc = 0;
    while (!bus1.done && cyc < 400) begin tick(); cyc++; end
    checks++; if (bus1.errors !== 2'd3) begin failures++; $display("FAIL sat_errors got=%0d exp=3", bus1.errors); end
    checks++; if ({bus1.first_err_vld, bus1.first_err_idx} !== 5'b10000) begin failures++; $display("FAIL sat_feidx got=%0d exp=0", bus1.first_err_idx); end
    checks++; if ({bus1.done, bus1.pass} !== 2'b10) begin failures++; $display("FAIL sat_done_pass got=%0d exp=2", {bus1.done, bus1.pass}); end
    checks++; if (cyc !== 24) begin failures++; $display("FAIL sat_cycles got=%0d exp=24", cyc); end
  endtask

  initial begin
    bus0.wr_en = 1'b0; bus0.wr_addr = 4'd0; bus0.wr_data = 5'd0;
    bus0.start = 1'b0; bus0.vec_count = 5'd0; bus0.stop_on_err = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_addr = 4'd0; bus1.wr_data = 5'd0;
    bus1.start = 1'b0; bus1.vec_count = 5'd0; bus1.stop_on_err = 1'b0;
    test_reset();
    test_exhaustive();
    test_one_error();
    test_stop_on_err();
    test_mask();
    test_zero_count();
    test_reset_midrun();
    test_busy_ignore();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
